// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC interrupt gateway: state encoding,
// default sizing and the claim/complete ID decode helper.
package plic_pkg;

  localparam int unsigned NUM_SRC_DEF = 32;
  localparam int unsigned ID_W_DEF    = 10;

  // Gateway state per source; irq_req is decoded straight from PEND.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_SERV = 2'b10
  } gw_state_e;

  // Result of translating a bus ID into a source index.
  typedef struct packed {
    logic        valid;
    logic [31:0] idx;
  } id_dec_t;

  // ID 0 is reserved and IDs above num_src name no source; both decode invalid.
  function automatic id_dec_t id_to_idx(input int unsigned id,
                                        input int unsigned num_src);
    id_dec_t dec;
    dec.valid = (id != 0) && (id <= num_src);
    dec.idx   = dec.valid ? (id - 1) : 32'd0;
    return dec;
  endfunction

endpackage

// File: rtl/plic_gateway_multi_src.sv
// One gateway source: request FSM, saturating edge-pending counter and
// sticky overflow flag. Inputs are already synchronised by the top level.
module plic_gw_src
  import plic_pkg::*;
#(
  parameter int unsigned MAX_PEND = 7,
  parameter int unsigned CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lvl,          // synchronised level as seen by the FSM
  input  logic             rise,         // one-cycle rising-edge strobe
  input  logic             cfg_edge,
  input  logic             claim_hit,
  input  logic             complete_hit,
  input  logic             ovf_clear,
  output logic             irq_req,
  output logic             pend_ovf,
  output logic [CNT_W-1:0] cnt
);

  gw_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_ovf_q, pend_ovf_d;

  logic cnt_full;
  logic cnt_nz;
  logic claim_take;

  assign cnt_full   = (cnt_q == CNT_W'(MAX_PEND));
  assign cnt_nz     = (cnt_q != '0);
  // A claim only takes effect when this source is actually pending.
  assign claim_take = claim_hit && (state_q == ST_PEND);

  // State, counter and overflow registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_ovf_q <= pend_ovf_d;
    end
  end

  // Next-state logic: forward one request, hold it until completed.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_edge ? cnt_nz : lvl) state_d = ST_PEND;
      end
      ST_PEND: begin
        // Claim beats a same-cycle complete and a same-cycle level drop.
        if (claim_hit)               state_d = ST_SERV;
        else if (!cfg_edge && !lvl)  state_d = ST_IDLE;
      end
      ST_SERV: begin
        if (complete_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Edge-pending counter and sticky overflow update.
  always_comb begin
    cnt_d      = cnt_q;
    pend_ovf_d = pend_ovf_q & ~ovf_clear;
    if (!cfg_edge) begin
      cnt_d = '0;
    end else if (rise && claim_take) begin
      cnt_d = cnt_q;
    end else if (rise) begin
      if (cnt_full) pend_ovf_d = 1'b1;
      else          cnt_d      = cnt_q + CNT_W'(1);
    end else if (claim_take && cnt_nz) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Outputs decoded from registers only.
  always_comb begin
    irq_req  = (state_q == ST_PEND);
    pend_ovf = pend_ovf_q;
    cnt      = cnt_q;
  end

endmodule

// File: rtl/plic_gateway_multi.sv
// Multi-source PLIC gateway: input synchronisers, edge detection and
// one-hot claim/complete decode feeding one plic_gw_src per source.
module plic_gateway_multi
  import plic_pkg::*;
#(
  parameter int unsigned NUM_SRC     = NUM_SRC_DEF,
  parameter int unsigned ID_W        = ID_W_DEF,
  parameter int unsigned MAX_PEND    = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [NUM_SRC-1:0] cfg_edge,
  input  logic               claim_valid,
  input  logic [ID_W-1:0]    claim_id,
  input  logic               complete_valid,
  input  logic [ID_W-1:0]    complete_id,
  input  logic [NUM_SRC-1:0] ovf_clear,
  output logic [NUM_SRC-1:0] irq_req,
  output logic [NUM_SRC-1:0] pend_ovf
);

  localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_d [SYNC_STAGES];
  logic [NUM_SRC-1:0] s_dly_q, s_dly_d;
  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] rise;
  id_dec_t            claim_dec;
  id_dec_t            complete_dec;

  // Synchroniser shift chain plus the one-cycle delayed copy for edge detect.
  always_comb begin
    sync_d[0] = src_irq;
    for (int k = 1; k < int'(SYNC_STAGES); k++) sync_d[k] = sync_q[k-1];
    s_dly_d = s;
  end

  // Synchroniser and delay registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
      s_dly_q <= '0;
    end else begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_d[k];
      s_dly_q <= s_dly_d;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_dly_q;

  assign claim_dec    = id_to_idx(32'(claim_id), NUM_SRC);
  assign complete_dec = id_to_idx(32'(complete_id), NUM_SRC);

  for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_src
    logic             claim_hit;
    logic             complete_hit;
    logic [CNT_W-1:0] cnt;

    assign claim_hit    = claim_valid && claim_dec.valid &&
                          (claim_dec.idx == 32'(i));
    assign complete_hit = complete_valid && complete_dec.valid &&
                          (complete_dec.idx == 32'(i));

    // The level path looks at the delayed copy so level and edge requests
    // share the same input-to-request latency.
    plic_gw_src #(
      .MAX_PEND (MAX_PEND),
      .CNT_W    (CNT_W)
    ) u_src (
      .clk          (clk),
      .rst          (rst),
      .lvl          (s_dly_q[i]),
      .rise         (rise[i]),
      .cfg_edge     (cfg_edge[i]),
      .claim_hit    (claim_hit),
      .complete_hit (complete_hit),
      .ovf_clear    (ovf_clear[i]),
      .irq_req      (irq_req[i]),
      .pend_ovf     (pend_ovf[i]),
      .cnt          (cnt)
    );
  end

endmodule

// File: tb/tb_plic_gateway_multi.sv
// Directed self-checking bench for plic_gateway_multi (8 sources, 4-bit IDs).
module tb_plic_gateway_multi;

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned ID_W    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] src_irq;
  logic [NUM_SRC-1:0] cfg_edge;
  logic               claim_valid;
  logic [ID_W-1:0]    claim_id;
  logic               complete_valid;
  logic [ID_W-1:0]    complete_id;
  logic [NUM_SRC-1:0] ovf_clear;
  logic [NUM_SRC-1:0] irq_req;
  logic [NUM_SRC-1:0] pend_ovf;

  int errors = 0;
  int checks = 0;

  plic_gateway_multi #(
    .NUM_SRC     (NUM_SRC),
    .ID_W        (ID_W),
    .MAX_PEND    (7),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .src_irq        (src_irq),
    .cfg_edge       (cfg_edge),
    .claim_valid    (claim_valid),
    .claim_id       (claim_id),
    .complete_valid (complete_valid),
    .complete_id    (complete_id),
    .ovf_clear      (ovf_clear),
    .irq_req        (irq_req),
    .pend_ovf       (pend_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int idx, input int n);
    repeat (n) begin
      src_irq[idx] = 1'b1;
      tick();
      src_irq[idx] = 1'b0;
      tick();
    end
  endtask

  task automatic claim(input int id);
    claim_valid = 1'b1;
    claim_id    = ID_W'(id);
    tick();
    claim_valid = 1'b0;
    claim_id    = '0;
  endtask

  task automatic complete(input int id);
    complete_valid = 1'b1;
    complete_id    = ID_W'(id);
    tick();
    complete_valid = 1'b0;
    complete_id    = '0;
  endtask

  initial begin
    rst            = 1'b1;
    src_irq        = '0;
    cfg_edge       = 8'b0010_0001;   // sources 0 and 5 edge mode, rest level
    claim_valid    = 1'b0;
    claim_id       = '0;
    complete_valid = 1'b0;
    complete_id    = '0;
    ovf_clear      = '0;
    tick(2);
    check("reset_irq_req", 32'(irq_req), 32'h0);
    check("reset_pend_ovf", 32'(pend_ovf), 32'h0);
    rst = 1'b0;
    tick();

    // 1: level source 3 (ID 4), latency, claim, complete, re-request
    src_irq[3] = 1'b1;
    tick(3);
    check("lvl_latency_early", 32'(irq_req[3]), 32'h0);
    tick();
    check("lvl_latency_req", 32'(irq_req[3]), 32'h1);
    claim(4);
    check("lvl_claimed", 32'(irq_req[3]), 32'h0);
    tick(3);
    check("lvl_serv_hold", 32'(irq_req[3]), 32'h0);
    complete(4);
    check("lvl_complete_idle", 32'(irq_req[3]), 32'h0);
    tick();
    check("lvl_rerequest", 32'(irq_req[3]), 32'h1);
    src_irq[3] = 1'b0;
    tick(5);
    check("lvl_released", 32'(irq_req[3]), 32'h0);

    // 2: edge source 0, three pulses served by three claim/complete pairs
    pulse(0, 3);
    tick(4);
    check("edge_cnt3", 32'(dut.g_src[0].u_src.cnt_q), 32'd3);
    for (int n = 0; n < 3; n++) begin
      check($sformatf("edge_req_%0d", n), 32'(irq_req[0]), 32'h1);
      claim(1);
      complete(1);
      tick();
    end
    check("edge_cnt_drained", 32'(dut.g_src[0].u_src.cnt_q), 32'd0);
    check("edge_req_quiet", 32'(irq_req[0]), 32'h0);

    // 3: saturation and overflow on source 0
    pulse(0, 9);
    tick(4);
    check("sat_cnt7", 32'(dut.g_src[0].u_src.cnt_q), 32'd7);
    check("sat_ovf_set", 32'(pend_ovf[0]), 32'h1);
    ovf_clear[0] = 1'b1;
    tick();
    ovf_clear[0] = 1'b0;
    check("sat_ovf_cleared", 32'(pend_ovf[0]), 32'h0);
    for (int n = 0; n < 7; n++) begin
      claim(1);
      complete(1);
      tick();
    end
    check("sat_drained_cnt", 32'(dut.g_src[0].u_src.cnt_q), 32'd0);
    check("sat_drained_req", 32'(irq_req[0]), 32'h0);
    check("sat_ovf_stays", 32'(pend_ovf[0]), 32'h0);

    // 4: level withdraw on source 2 (ID 3)
    src_irq[2] = 1'b1;
    tick(4);
    check("wd_req", 32'(irq_req[2]), 32'h1);
    src_irq[2] = 1'b0;
    tick(3);
    check("wd_still_req", 32'(irq_req[2]), 32'h1);
    tick();
    check("wd_withdrawn", 32'(irq_req[2]), 32'h0);
    claim(3);
    check("wd_late_claim_req", 32'(irq_req[2]), 32'h0);
    check("wd_late_claim_state", 32'(dut.g_src[2].u_src.state_q), 32'h0);

    // 5: illegal IDs and a claim on an idle source
    src_irq[1] = 1'b1;
    tick(4);
    check("ill_setup_req", 32'(irq_req), 32'h02);
    claim(2);
    check("ill_setup_serv", 32'(dut.g_src[1].u_src.state_q), 32'h2);
    complete(0);
    complete(NUM_SRC + 1);
    check("ill_cpl_state", 32'(dut.g_src[1].u_src.state_q), 32'h2);
    check("ill_cpl_req", 32'(irq_req), 32'h00);
    claim(7);
    check("ill_idle_claim_req", 32'(irq_req), 32'h00);
    check("ill_idle_claim_state", 32'(dut.g_src[6].u_src.state_q), 32'h0);
    src_irq[1] = 1'b0;
    complete(2);
    tick(6);
    check("ill_all_quiet", 32'(irq_req), 32'h00);

    // 6: reset while source 5 is in service with two pending edges
    src_irq[3] = 1'b1;
    pulse(5, 3);
    tick(4);
    claim(6);
    check("rst_pre_state5", 32'(dut.g_src[5].u_src.state_q), 32'h2);
    check("rst_pre_cnt5", 32'(dut.g_src[5].u_src.cnt_q), 32'd2);
    check("rst_pre_req", 32'(irq_req), 32'h08);
    rst = 1'b1;
    tick();
    check("rst_irq_req", 32'(irq_req), 32'h00);
    check("rst_cnt5", 32'(dut.g_src[5].u_src.cnt_q), 32'd0);
    check("rst_state5", 32'(dut.g_src[5].u_src.state_q), 32'h0);
    check("rst_pend_ovf", 32'(pend_ovf), 32'h00);
    rst = 1'b0;
    tick(3);
    check("rst_relatency_early", 32'(irq_req[3]), 32'h0);
    tick();
    check("rst_relatency_req", 32'(irq_req[3]), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
